// File: rtl/dma_responder.sv
// Single-channel DMA responder: moves 16-byte beats between a host bus and a local dual-port SRAM.
// One host transaction is outstanding at a time; dma_ack pulses once per completed request.
module dma_responder #(
    parameter int unsigned HOST_AW = 40,
    parameter int unsigned DW      = 128,
    parameter int unsigned SRAM_AW = 12
) (
    input  logic               clk,
    input  logic               rstn,
    // NPU core request side
    input  logic               dma_req,
    output logic               dma_ready,
    input  logic               dma_rwn,
    input  logic [HOST_AW-1:0] dma_hostAddr,
    input  logic [15:0]        dma_localAddr,
    input  logic [15:0]        dma_tansferLength,
    output logic               dma_ack,
    // Host bus
    output logic               host_req,
    output logic               host_we,
    output logic [HOST_AW-1:0] host_addr,
    output logic [DW-1:0]      host_wdata,
    input  logic               host_gnt,
    input  logic               host_rvalid,
    input  logic [DW-1:0]      host_rdata,
    // Local SRAM, port A write / port B read
    output logic               sram_ena,
    output logic               sram_wea,
    output logic [SRAM_AW-1:0] sram_addra,
    output logic [DW-1:0]      sram_dina,
    output logic               sram_enb,
    output logic [SRAM_AW-1:0] sram_addrb,
    input  logic [DW-1:0]      sram_doutb
);

    typedef enum logic [2:0] {
        StIdle,
        StRreq,
        StRdat,
        StSrd,
        StScap,
        StWreq,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [HOST_AW-1:0] haddr_q, haddr_d;
    logic [SRAM_AW-1:0] laddr_q, laddr_d;
    logic [11:0]        count_q, count_d;
    logic [DW-1:0]      wdata_q, wdata_d;
    logic               beat_done;

    // Sub-beat address and length bits are ignored by design.
    logic unused_low_bits;
    assign unused_low_bits = ^{dma_hostAddr[3:0], dma_localAddr[3:0], dma_tansferLength[3:0]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            haddr_q <= '0;
            laddr_q <= '0;
            count_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            haddr_q <= haddr_d;
            laddr_q <= laddr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        laddr_d    = laddr_q;
        count_d    = count_q;
        wdata_d    = wdata_q;
        beat_done  = 1'b0;

        dma_ready  = 1'b0;
        dma_ack    = 1'b0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = haddr_q;
        host_wdata = wdata_q;
        sram_ena   = 1'b0;
        sram_wea   = 1'b0;
        sram_addra = '0;
        sram_dina  = '0;
        sram_enb   = 1'b0;
        sram_addrb = '0;

        case (state_q)
            StIdle: begin
                dma_ready = 1'b1;
                if (dma_req) begin
                    haddr_d = {dma_hostAddr[HOST_AW-1:4], 4'b0000};
                    laddr_d = SRAM_AW'(dma_localAddr[15:4]);
                    count_d = dma_tansferLength[15:4];
                    if (dma_tansferLength[15:4] == 12'd0) begin
                        state_d = StDone;
                    end else if (dma_rwn) begin
                        state_d = StRreq;
                    end else begin
                        state_d = StSrd;
                    end
                end
            end
            StRreq: begin
                host_req = 1'b1;
                if (host_gnt) begin
                    state_d = StRdat;
                end
            end
            StRdat: begin
                if (host_rvalid) begin
                    sram_ena   = 1'b1;
                    sram_wea   = 1'b1;
                    sram_addra = laddr_q;
                    sram_dina  = host_rdata;
                    beat_done  = 1'b1;
                    state_d    = (count_q == 12'd1) ? StDone : StRreq;
                end
            end
            StSrd: begin
                sram_enb   = 1'b1;
                sram_addrb = laddr_q;
                state_d    = StScap;
            end
            StScap: begin
                // SRAM read data is valid exactly one cycle after the enable.
                wdata_d = sram_doutb;
                state_d = StWreq;
            end
            StWreq: begin
                host_req = 1'b1;
                host_we  = 1'b1;
                if (host_gnt) begin
                    beat_done = 1'b1;
                    state_d   = (count_q == 12'd1) ? StDone : StSrd;
                end
            end
            StDone: begin
                dma_ack = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (beat_done) begin
            count_d = count_q - 12'd1;
            haddr_d = haddr_q + HOST_AW'(16);
            laddr_d = laddr_q + SRAM_AW'(1);
        end
    end

endmodule

// File: tb/tb_dma_responder.sv
// Randomised self-checking bench for dma_responder with a behavioural host/SRAM model.
`timescale 1ns/1ps
module tb_dma_responder;

    localparam int unsigned HOST_AW = 40;
    localparam int unsigned DW      = 128;
    localparam int unsigned SRAM_AW = 12;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               dma_req = 1'b0;
    logic               dma_ready;
    logic               dma_rwn = 1'b0;
    logic [HOST_AW-1:0] dma_hostAddr = '0;
    logic [15:0]        dma_localAddr = '0;
    logic [15:0]        dma_tansferLength = '0;
    logic               dma_ack;
    logic               host_req;
    logic               host_we;
    logic [HOST_AW-1:0] host_addr;
    logic [DW-1:0]      host_wdata;
    logic               host_gnt = 1'b0;
    logic               host_rvalid = 1'b0;
    logic [DW-1:0]      host_rdata = '0;
    logic               sram_ena;
    logic               sram_wea;
    logic [SRAM_AW-1:0] sram_addra;
    logic [DW-1:0]      sram_dina;
    logic               sram_enb;
    logic [SRAM_AW-1:0] sram_addrb;
    logic [DW-1:0]      sram_doutb = '0;

    dma_responder #(
        .HOST_AW(HOST_AW),
        .DW     (DW),
        .SRAM_AW(SRAM_AW)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .dma_req          (dma_req),
        .dma_ready        (dma_ready),
        .dma_rwn          (dma_rwn),
        .dma_hostAddr     (dma_hostAddr),
        .dma_localAddr    (dma_localAddr),
        .dma_tansferLength(dma_tansferLength),
        .dma_ack          (dma_ack),
        .host_req         (host_req),
        .host_we          (host_we),
        .host_addr        (host_addr),
        .host_wdata       (host_wdata),
        .host_gnt         (host_gnt),
        .host_rvalid      (host_rvalid),
        .host_rdata       (host_rdata),
        .sram_ena         (sram_ena),
        .sram_wea         (sram_wea),
        .sram_addra       (sram_addra),
        .sram_dina        (sram_dina),
        .sram_enb         (sram_enb),
        .sram_addrb       (sram_addrb),
        .sram_doutb       (sram_doutb)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] sram_mem [0:4095];
    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // SRAM read port: data one cycle after enable, garbage otherwise.
    always @(posedge clk) begin
        if (sram_enb) sram_doutb <= sram_mem[sram_addrb];
        else          sram_doutb <= rand_word();
    end

    task automatic do_transfer(input logic rwn, input logic [HOST_AW-1:0] haddr,
                               input logic [15:0] laddr, input logic [15:0] len,
                               input int stall_min, input int stall_max, input int rv_max,
                               input bit noise, input bit check_lat, input string name);
        int nb, issued, sram_wr, sram_rd, acks, cyc, stall_left, rv_wait, ack_cyc, exp_lat;
        bit pend, done, legit_rv;
        logic [DW-1:0] cur_rdata, exp_wd;
        logic [HOST_AW-1:0] base, ea;
        logic [11:0] el;
        nb = int'(len >> 4);
        base = {haddr[HOST_AW-1:4], 4'b0000};
        exp_lat = (nb == 0) ? 1 : (rwn ? 2 * nb + 1 : 3 * nb + 1);
        issued = 0; sram_wr = 0; sram_rd = 0; acks = 0; cyc = 0; ack_cyc = 0; rv_wait = 0;
        pend = 0; done = 0; cur_rdata = '0;
        stall_left = int'($urandom_range(stall_max, stall_min));

        @(posedge clk); #1;
        dma_req = 1'b1; dma_rwn = rwn; dma_hostAddr = haddr;
        dma_localAddr = laddr; dma_tansferLength = len;
        host_gnt = 1'b0; host_rvalid = 1'b0;
        #2;
        n_checks++;
        if (dma_ready !== 1'b1) begin
            n_errors++; $display("FAIL %s ready_at_req: got %b want 1", name, dma_ready);
        end

        while (!done && cyc < 400) begin
            @(posedge clk); #1; cyc++;
            host_gnt = 1'b0; host_rvalid = 1'b0; host_rdata = rand_word(); legit_rv = 0;
            if (noise && acks == 0) begin
                dma_req = 1'($urandom_range(1, 0)); dma_rwn = 1'($urandom_range(1, 0));
                dma_hostAddr = HOST_AW'({$urandom(), $urandom()});
                dma_localAddr = 16'($urandom()); dma_tansferLength = 16'($urandom());
            end else begin
                dma_req = 1'b0;
            end
            if (pend) begin
                if (rv_wait == 0) begin
                    host_rvalid = 1'b1; host_rdata = cur_rdata; pend = 0; legit_rv = 1;
                end else begin
                    rv_wait--;
                end
            end else if (noise && $urandom_range(3, 0) == 0) begin
                host_rvalid = 1'b1;
            end
            #1;
            if (host_req) begin
                ea = base + (HOST_AW'(issued) << 4);
                el = laddr[15:4] + 12'(issued);
                n_checks++;
                if (issued >= nb || pend) begin
                    n_errors++;
                    $display("FAIL %s host_req_unexpected: issued %0d of %0d pend %0b",
                             name, issued, nb, pend);
                end else begin
                    n_checks++;
                    if (host_addr !== ea || host_we !== ~rwn) begin
                        n_errors++;
                        $display("FAIL %s host_addr_we: got %h/%b want %h/%b",
                                 name, host_addr, host_we, ea, ~rwn);
                    end
                    if (!rwn) begin
                        exp_wd = sram_mem[el];
                        n_checks++;
                        if (host_wdata !== exp_wd) begin
                            n_errors++;
                            $display("FAIL %s host_wdata: got %h want %h", name, host_wdata, exp_wd);
                        end
                    end
                    if (stall_left == 0) begin
                        host_gnt = 1'b1; issued++;
                        stall_left = int'($urandom_range(stall_max, stall_min));
                        if (rwn) begin
                            pend = 1; rv_wait = int'($urandom_range(rv_max, 0)); cur_rdata = rand_word();
                        end
                    end else begin
                        stall_left--;
                    end
                end
            end
            #1;
            if (sram_ena || sram_wea || legit_rv) begin
                el = laddr[15:4] + 12'(sram_wr);
                n_checks++;
                if (!legit_rv || !sram_ena || !sram_wea || sram_wr >= nb) begin
                    n_errors++;
                    $display("FAIL %s sram_write_event: ena %b wea %b rvalid_expected %0b wr %0d",
                             name, sram_ena, sram_wea, legit_rv, sram_wr);
                end else if (sram_addra !== el || sram_dina !== cur_rdata) begin
                    n_errors++;
                    $display("FAIL %s sram_write: got %h/%h want %h/%h",
                             name, sram_addra, sram_dina, el, cur_rdata);
                end
                if (sram_ena && sram_wea) sram_mem[sram_addra] = sram_dina;
                sram_wr++;
            end
            if (sram_enb) begin
                el = laddr[15:4] + 12'(sram_rd);
                n_checks++;
                if (rwn || sram_rd >= nb || sram_addrb !== el) begin
                    n_errors++;
                    $display("FAIL %s sram_read: got %h want %h (rd %0d of %0d)",
                             name, sram_addrb, el, sram_rd, nb);
                end
                sram_rd++;
            end
            if (dma_ack) begin
                acks++; ack_cyc = cyc;
                n_checks++;
                if (acks > 1 || issued != nb || (rwn ? sram_wr : sram_rd) != nb) begin
                    n_errors++;
                    $display("FAIL %s ack: acks %0d beats %0d/%0d want %0d", name, acks, issued,
                             rwn ? sram_wr : sram_rd, nb);
                end
                if (check_lat) begin
                    n_checks++;
                    if (cyc != exp_lat) begin
                        n_errors++;
                        $display("FAIL %s ack_latency: got %0d want %0d", name, cyc, exp_lat);
                    end
                end
            end else if (acks == 1 && cyc == ack_cyc + 1) begin
                n_checks++;
                if (dma_ready !== 1'b1) begin
                    n_errors++; $display("FAIL %s ready_after_ack: got %b want 1", name, dma_ready);
                end
                done = 1;
            end else if (acks == 0) begin
                n_checks++;
                if (dma_ready !== 1'b0) begin
                    n_errors++; $display("FAIL %s ready_while_busy: got %b want 0", name, dma_ready);
                end
            end
        end
        dma_req = 1'b0;
        n_checks++;
        if (!done) begin
            n_errors++; $display("FAIL %s timeout: acks %0d issued %0d want %0d", name, acks, issued, nb);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; dma_req = 1'b1; host_rvalid = 1'b1; host_rdata = rand_word();
        repeat (3) @(posedge clk);
        #1; dma_req = 1'b0; host_rvalid = 1'b0;
        #1;
        n_checks++;
        if ({dma_ready, dma_ack, host_req, host_we, sram_ena, sram_wea, sram_enb} !== 7'b1000000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b want 1000000",
                     {dma_ready, dma_ack, host_req, host_we, sram_ena, sram_wea, sram_enb});
        end
        n_checks++;
        if (host_addr !== '0 || host_wdata !== '0 || sram_addra !== '0 || sram_addrb !== '0 ||
            sram_dina !== '0) begin
            n_errors++;
            $display("FAIL reset_data: host_addr %h wdata %h addra %h addrb %h dina %h",
                     host_addr, host_wdata, sram_addra, sram_addrb, sram_dina);
        end
        rstn = 1'b1;
        @(posedge clk); #2;
        n_checks++;
        if (dma_ready !== 1'b1 || dma_ack !== 1'b0) begin
            n_errors++; $display("FAIL reset_release: ready %b ack %b want 1/0", dma_ready, dma_ack);
        end
    endtask

    task automatic test_read_basic();
        do_transfer(1'b1, 40'h00_0000_1000, 16'h0040, 16'd64, 0, 0, 0, 1'b0, 1'b1, "read_64B");
    endtask

    task automatic test_write_basic();
        do_transfer(1'b0, HOST_AW'({$urandom(), $urandom()}), 16'h0000, 16'd32, 0, 0, 0, 1'b0, 1'b1,
                    "write_32B");
    endtask

    task automatic test_zero_len();
        do_transfer(1'b1, 40'h00_0000_2000, 16'h0100, 16'h000F, 0, 0, 0, 1'b0, 1'b1, "zero_len_rd");
        do_transfer(1'b0, 40'h00_0000_3000, 16'h0200, 16'h0000, 0, 0, 0, 1'b0, 1'b1, "zero_len_wr");
    endtask

    task automatic test_local_wrap();
        do_transfer(1'b1, 40'h00_0000_4000, 16'hFFF0, 16'd32, 0, 0, 0, 1'b0, 1'b1, "local_wrap");
        do_transfer(1'b0, 40'hFF_FFFF_FFE7, 16'hFFE0, 16'd64, 0, 0, 0, 1'b0, 1'b1, "host_wrap_wr");
    endtask

    task automatic test_stall();
        do_transfer(1'b1, 40'h00_0000_5008, 16'h0300, 16'd48, 3, 3, 0, 1'b1, 1'b0, "stall_rd");
        do_transfer(1'b0, 40'h00_0000_6000, 16'h0400, 16'd48, 3, 3, 0, 1'b1, 1'b0, "stall_wr");
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic [HOST_AW-1:0] ha;
            ha = ($urandom_range(1, 0) == 1) ? HOST_AW'({$urandom(), $urandom()})
                                              : 40'hFF_FFFF_FF00 + HOST_AW'($urandom_range(255, 0));
            do_transfer(1'($urandom_range(1, 0)), ha, 16'($urandom()),
                        16'($urandom_range(8, 0) * 16 + $urandom_range(15, 0)),
                        0, 3, 2, 1'b1, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        dma_req = 1'b1; dma_rwn = 1'b1; dma_hostAddr = 40'h00_0000_7000;
        dma_localAddr = 16'h0500; dma_tansferLength = 16'd64; host_gnt = 1'b0; host_rvalid = 1'b0;
        @(posedge clk); #1;
        dma_req = 1'b0; host_gnt = 1'b1;
        @(posedge clk); #1;
        host_gnt = 1'b0;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (host_req !== 1'b0 || sram_ena !== 1'b0) begin
            n_errors++; $display("FAIL rst_mid_in_rdat: host_req %b ena %b want 0/0", host_req, sram_ena);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 2) rstn = 1'b1;
            host_rvalid = 1'b1; host_rdata = rand_word();
            #1;
            n_checks++;
            if ({sram_ena, sram_wea, sram_enb, host_req, dma_ack} !== 5'b00000 ||
                (i > 2 && dma_ready !== 1'b1) || host_addr !== '0) begin
                n_errors++;
                $display("FAIL rst_mid_quiet[%0d]: ena/wea/enb/req/ack %b ready %b host_addr %h",
                         i, {sram_ena, sram_wea, sram_enb, host_req, dma_ack}, dma_ready, host_addr);
            end
        end
        host_rvalid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) sram_mem[i] = rand_word();
        test_reset();
        test_read_basic();
        test_write_basic();
        test_zero_len();
        test_local_wrap();
        test_stall();
        test_random();
        test_reset_mid();
        test_read_basic();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dma_responder.md
DMA_RESPONDER -- requirements
Module: dma_responder

Interface
REQ-001 SHALL have parameter HOST_AW, 40, host byte-address width.
REQ-002 SHALL have parameter DW, 128, beat width in bits (16 bytes).
REQ-003 SHALL have parameter SRAM_AW, 12, local SRAM word-address width.
REQ-004 SHALL have ports:
- clk  in  1  sole clock; one clock, all logic on rising edge.
- rstn  in  1  reset, synchronous, active-low.
- dma_req  in  1  NPU core transfer request.
- dma_ready  out  1  responder idle; accepts a request.
- dma_rwn  in  1  1 = host->local (read host), 0 = local->host (write host).
- dma_hostAddr  in  HOST_AW  host byte start address.
- dma_localAddr  in  16  local byte start address.
- dma_tansferLength  in  16  length in bytes.
- dma_ack  out  1  one-cycle completion pulse.
- host_req  out  1  host bus request.
- host_we  out  1  host write (1) / read (0).
- host_addr  out  HOST_AW  host beat byte address.
- host_wdata  out  DW  host write data.
- host_gnt  in  1  host accepted request this cycle.
- host_rvalid  in  1  host read data valid.
- host_rdata  in  DW  host read data.
- sram_ena, sram_wea  out  1 each  SRAM write enables.
- sram_addra  out  SRAM_AW  SRAM write address.
- sram_dina  out  DW  SRAM write data.
- sram_enb  out  1  SRAM read enable.
- sram_addrb  out  SRAM_AW  SRAM read address.
- sram_doutb  in  DW  SRAM read data, valid the cycle after sram_enb.

Function
REQ-005 SHALL accept a request when dma_req && dma_ready, latching rwn, hostAddr, localAddr[15:4] (SRAM word address), and beat count = dma_tansferLength[15:4]; low 4 bits of length and of both addresses SHALL be ignored.
REQ-006 SHALL drive dma_ready=1 only in IDLE; dma_req outside IDLE SHALL be ignored.
REQ-007 SHALL implement states IDLE, RREQ, RDAT, SRD, SCAP, WREQ, DONE.
REQ-008 IDLE -> RREQ (rwn=1) or SRD (rwn=0) on accept; IDLE -> DONE if beat count is 0.
REQ-009 RREQ: host_req=1, host_we=0, host_addr=current host address held stable until host_gnt; on host_gnt -> RDAT.
REQ-010 RDAT: wait for host_rvalid (earliest the cycle after gnt); in that cycle sram_ena=sram_wea=1, sram_addra=current local word, sram_dina=host_rdata; decrement count; -> DONE if count becomes 0 else RREQ.
REQ-011 SRD: sram_enb=1, sram_addrb=current local word, one cycle -> SCAP.
REQ-012 SCAP: register sram_doutb into host_wdata -> WREQ.
REQ-013 WREQ: host_req=1, host_we=1, host_addr, host_wdata held until host_gnt; on gnt decrement count; -> DONE if 0 else SRD.
REQ-014 After each completed beat host address SHALL add 16 (mod 2^HOST_AW) and local word address SHALL add 1 (mod 2^SRAM_AW; 4095 wraps to 0).
REQ-015 DONE: dma_ack=1 for exactly one cycle -> IDLE; dma_ready returns 1 the following cycle.
REQ-016 Minimum per-beat latency with host_gnt immediate and host_rvalid next cycle: 2 cycles (read), 3 cycles (write).
REQ-017 At most one host transaction outstanding; host_rvalid outside RDAT SHALL be ignored.
REQ-018 SRAM enables SHALL be zero in every state/cycle not listed above.

Reset
REQ-019 On rstn=0 at a clock edge: state=IDLE, dma_ready=1 on the first cycle after rstn rises, dma_ack=0, host_req=0, host_we=0, host_addr=0, host_wdata=0, all SRAM enables 0, addresses/data 0, count 0.
REQ-020 Reset mid-transfer SHALL abort without further SRAM or host activity and without dma_ack.

Verification
REQ-021 Read 64 B, hostAddr=0x1000, localAddr=0x0040, gnt/rvalid immediate -> 4 SRAM writes to addr 0x004..0x007 with host data, host_addr 0x1000..0x1030, dma_ack 8 cycles after RREQ entry.
REQ-022 Write 32 B, localAddr=0x0000 -> sram_addrb 0,1; host writes to hostAddr, hostAddr+16 with matching SRAM words; one dma_ack.
REQ-023 Length 0 -> dma_ack the cycle after accept, no host_req, no SRAM enables.
REQ-024 localAddr=0xFFF0, read 32 B -> SRAM writes at 0xFFF then 0x000.
REQ-025 host_gnt delayed 3 cycles, dma_req pulsed while busy -> host_req/addr stable through stall, second request ignored, single dma_ack.
REQ-026 rstn low during RDAT of a 4-beat read -> no SRAM write after reset, no dma_ack, dma_ready=1 after release.
